// File: rtl/ghost_mode_scheduler_if.sv
// Bundle between game-state logic and the ghost mode scheduler.
// The game side drives the event strobes; the scheduler returns the mode outputs.
`timescale 1ns/1ps
interface ghost_mode_scheduler_if;
  logic       tick;
  logic       gameEn;
  logic       powerPellet;
  logic [3:0] ghostEaten;
  logic [3:0] ghostHome;
  logic [1:0] globalMode;
  logic [7:0] ghostMode;
  logic [3:0] reverseDir;
  logic       flash;
  logic       eatValid;
  logic [1:0] eatIdx;

  modport master (
    output tick, gameEn, powerPellet, ghostEaten, ghostHome,
    input  globalMode, ghostMode, reverseDir, flash, eatValid, eatIdx
  );

  modport slave (
    input  tick, gameEn, powerPellet, ghostEaten, ghostHome,
    output globalMode, ghostMode, reverseDir, flash, eatValid, eatIdx
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global scatter/chase phase table, frightened window and per-ghost
// normal/fright/eaten tracking for the four ghosts; all outputs registered.
`timescale 1ns/1ps
module ghost_mode_scheduler #(
  parameter int SCATTER_T  = 420,
  parameter int SCATTER2_T = 300,
  parameter int CHASE_T    = 1200,
  parameter int FRIGHT_T   = 360,
  parameter int FLASH_T    = 120,
  parameter int TW         = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  ghost_mode_scheduler_if.slave bus
);

  localparam logic [TW-1:0] SCAT_LAST   = TW'(SCATTER_T - 1);
  localparam logic [TW-1:0] SCAT2_LAST  = TW'(SCATTER2_T - 1);
  localparam logic [TW-1:0] CHASE_LAST  = TW'(CHASE_T - 1);
  localparam logic [TW-1:0] FRIGHT_LAST = TW'(FRIGHT_T - 1);
  localparam logic [TW-1:0] FLASH_START = TW'(FRIGHT_T - FLASH_T);

  typedef enum logic [1:0] {
    GH_NORMAL = 2'd0,
    GH_FRIGHT = 2'd1,
    GH_EATEN  = 2'd2
  } ghost_state_t;

  logic          qtick, pellet;
  logic [3:0]    eat_req, home_req, eat_hit;
  logic [2:0]    phase_reg, phase_next;
  logic [TW-1:0] ptimer_reg, ptimer_next, phase_last;
  logic          phase_end;
  logic          fright_reg, fright_next, fright_end;
  logic [TW-1:0] ftimer_reg, ftimer_next;
  logic [1:0]    count_reg, count_next;
  logic [2:0]    eat_cnt, count_sum;
  logic [1:0]    global_mode_reg;
  logic          flash_reg, eat_valid_reg;
  logic [1:0]    eat_idx_reg;
  logic [7:0]    ghost_mode_w;
  logic [3:0]    reverse_w;

  // Events are only honoured while the level is running; otherwise they are dropped.
  assign qtick    = bus.tick & bus.gameEn;
  assign pellet   = bus.powerPellet & bus.gameEn;
  assign eat_req  = bus.ghostEaten & {4{bus.gameEn}};
  assign home_req = bus.ghostHome & {4{bus.gameEn}};

  always_comb begin
    case (phase_reg)
      3'd0, 3'd2: phase_last = SCAT_LAST;
      3'd4, 3'd6: phase_last = SCAT2_LAST;
      default:    phase_last = CHASE_LAST;
    endcase
  end

  always_comb begin
    phase_next  = phase_reg;
    ptimer_next = ptimer_reg;
    phase_end   = 1'b0;
    if (!fright_reg && qtick && phase_reg != 3'd7) begin
      if (ptimer_reg == phase_last) begin
        phase_next  = phase_reg + 3'd1;
        ptimer_next = '0;
        phase_end   = 1'b1;
      end else begin
        ptimer_next = ptimer_reg + 1'b1;
      end
    end
  end

  assign fright_end = fright_reg && qtick && (ftimer_reg == FRIGHT_LAST);

  // A pellet on the closing tick restarts the window rather than ending it.
  always_comb begin
    fright_next = fright_reg;
    ftimer_next = ftimer_reg;
    if (pellet) begin
      fright_next = 1'b1;
      ftimer_next = '0;
    end else if (fright_end) begin
      fright_next = 1'b0;
      ftimer_next = '0;
    end else if (fright_reg && qtick) begin
      ftimer_next = ftimer_reg + 1'b1;
    end
  end

  always_comb begin
    eat_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      eat_cnt = eat_cnt + {2'b00, eat_hit[i]};
    end
    count_sum  = {1'b0, count_reg} + eat_cnt;
    count_next = count_reg;
    if (eat_cnt != 3'd0) begin
      count_next = (count_sum > 3'd3) ? 2'd3 : count_sum[1:0];
    end
    if (pellet || fright_end) begin
      count_next = 2'd0;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ghost
      ghost_state_t gs_reg, gs_next;
      logic         rev_next, rev_reg;
      logic [1:0]   mode_next, mode_reg;

      always_comb begin
        gs_next  = gs_reg;
        rev_next = 1'b0;
        unique case (gs_reg)
          GH_NORMAL: begin
            if (pellet) begin
              gs_next  = GH_FRIGHT;
              rev_next = 1'b1;
            end else if (phase_end) begin
              rev_next = 1'b1;
            end
          end
          GH_FRIGHT: begin
            if (eat_req[gi]) begin
              gs_next = GH_EATEN;
            end else if (fright_end && !pellet) begin
              gs_next = GH_NORMAL;
            end
          end
          GH_EATEN: begin
            if (home_req[gi]) begin
              gs_next = GH_NORMAL;
            end
          end
          default: gs_next = GH_NORMAL;
        endcase
      end

      always_comb begin
        case (gs_next)
          GH_FRIGHT: mode_next = 2'b10;
          GH_EATEN:  mode_next = 2'b11;
          default:   mode_next = {1'b0, phase_next[0]};
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          gs_reg   <= GH_NORMAL;
          rev_reg  <= 1'b0;
          mode_reg <= 2'b00;
        end else begin
          gs_reg   <= gs_next;
          rev_reg  <= rev_next;
          mode_reg <= mode_next;
        end
      end

      assign eat_hit[gi]             = eat_req[gi] && (gs_reg == GH_FRIGHT);
      assign ghost_mode_w[2*gi +: 2] = mode_reg;
      assign reverse_w[gi]           = rev_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg       <= 3'd0;
      ptimer_reg      <= '0;
      fright_reg      <= 1'b0;
      ftimer_reg      <= '0;
      count_reg       <= 2'd0;
      global_mode_reg <= 2'b00;
      flash_reg       <= 1'b0;
      eat_valid_reg   <= 1'b0;
      eat_idx_reg     <= 2'd0;
    end else begin
      phase_reg       <= phase_next;
      ptimer_reg      <= ptimer_next;
      fright_reg      <= fright_next;
      ftimer_reg      <= ftimer_next;
      count_reg       <= count_next;
      global_mode_reg <= fright_next ? 2'b10 : {1'b0, phase_next[0]};
      flash_reg       <= fright_next && (ftimer_next >= FLASH_START);
      eat_valid_reg   <= |eat_hit;
      eat_idx_reg     <= (|eat_hit) ? count_reg : 2'd0;
    end
  end

  assign bus.globalMode = global_mode_reg;
  assign bus.ghostMode  = ghost_mode_w;
  assign bus.reverseDir = reverse_w;
  assign bus.flash      = flash_reg;
  assign bus.eatValid   = eat_valid_reg;
  assign bus.eatIdx     = eat_idx_reg;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboard bench for ghost_mode_scheduler: a behavioural model queues the
// expected outputs per driven cycle; directed checks pin the key scenarios.
`timescale 1ns/1ps
module tb_ghost_mode_scheduler;
  localparam int SC = 4, SC2 = 3, CH = 6, FR = 5, FL = 2, TW = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ghost_mode_scheduler_if bus();

  ghost_mode_scheduler #(
    .SCATTER_T(SC), .SCATTER2_T(SC2), .CHASE_T(CH),
    .FRIGHT_T(FR), .FLASH_T(FL), .TW(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0] gm;
    logic [7:0] gh;
    logic [3:0] rv;
    logic       fl;
    logic       ev;
    logic [1:0] idx;
  } out_t;

  out_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  int m_phase, m_pt, m_fright, m_ft, m_cnt;
  int m_gs[4];  // 0 normal, 1 frightened, 2 eaten

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      0, 2:    return SC;
      4, 6:    return SC2;
      default: return CH;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pt = 0; m_fright = 0; m_ft = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_gs[i] = 0;
  endtask

  task automatic model_step(input logic t, input logic en, input logic pp,
                            input logic [3:0] ge, input logic [3:0] gh, output out_t e);
    int  n;
    bit  pend, fend;
    e = '0;
    if (en) begin
      pend = 0; fend = 0; n = 0;
      if (m_fright == 0 && t && m_phase < 7) begin
        if (m_pt == dur(m_phase) - 1) begin
          m_phase++; m_pt = 0; pend = 1;
        end else m_pt++;
      end
      if (m_fright == 1 && t) begin
        if (m_ft == FR - 1) fend = 1;
        else m_ft++;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_gs[i] == 0) begin
          if (pp) begin m_gs[i] = 1; e.rv[i] = 1'b1; end
          else if (pend) e.rv[i] = 1'b1;
        end else if (m_gs[i] == 1) begin
          if (ge[i]) begin m_gs[i] = 2; n++; end
          else if (fend && !pp) m_gs[i] = 0;
        end else begin
          if (gh[i]) m_gs[i] = 0;
        end
      end
      if (n > 0) begin
        e.ev = 1'b1;
        e.idx = 2'(m_cnt);
        m_cnt = (m_cnt + n > 3) ? 3 : m_cnt + n;
      end
      if (pp) begin m_fright = 1; m_ft = 0; m_cnt = 0; end
      else if (fend) begin m_fright = 0; m_ft = 0; m_cnt = 0; end
    end
    e.gm = (m_fright == 1) ? 2'b10 : 2'(m_phase % 2);
    for (int i = 0; i < 4; i++) begin
      case (m_gs[i])
        1:       e.gh[2*i +: 2] = 2'b10;
        2:       e.gh[2*i +: 2] = 2'b11;
        default: e.gh[2*i +: 2] = 2'(m_phase % 2);
      endcase
    end
    e.fl = (m_fright == 1) && (m_ft >= FR - FL);
  endtask

  task automatic cyc(input logic t, input logic en, input logic pp,
                     input logic [3:0] ge, input logic [3:0] gh);
    out_t e;
    bus.tick = t; bus.gameEn = en; bus.powerPellet = pp;
    bus.ghostEaten = ge; bus.ghostHome = gh;
    model_step(t, en, pp, ge, gh, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("globalMode", 32'(bus.globalMode), 32'(e.gm));
      check_val("ghostMode",  32'(bus.ghostMode),  32'(e.gh));
      check_val("reverseDir", 32'(bus.reverseDir), 32'(e.rv));
      check_val("flash",      32'(bus.flash),      32'(e.fl));
      check_val("eatValid",   32'(bus.eatValid),   32'(e.ev));
      check_val("eatIdx",     32'(bus.eatIdx),     32'(e.idx));
    end
    $display("t=%0t tick=%b en=%b pp=%b ge=%b gh=%b -> gm=%b ghost=%h rev=%h flash=%b ev=%b idx=%0d",
             $time, t, en, pp, ge, gh, bus.globalMode, bus.ghostMode, bus.reverseDir,
             bus.flash, bus.eatValid, bus.eatIdx);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_cleared(input string pfx);
    check_val({pfx, "_gm"},   32'(bus.globalMode), 32'd0);
    check_val({pfx, "_gh"},   32'(bus.ghostMode),  32'd0);
    check_val({pfx, "_rev"},  32'(bus.reverseDir), 32'd0);
    check_val({pfx, "_fl"},   32'(bus.flash),      32'd0);
    check_val({pfx, "_ev"},   32'(bus.eatValid),   32'd0);
    check_val({pfx, "_idx"},  32'(bus.eatIdx),     32'd0);
  endtask

  int bounds[7] = '{4, 10, 14, 20, 23, 29, 32};

  initial begin
    bus.tick = 1'b0; bus.gameEn = 1'b0; bus.powerPellet = 1'b0;
    bus.ghostEaten = 4'h0; bus.ghostHome = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b1;

    // Phase table: expected mode after k ticks from the listed durations.
    for (int k = 1; k <= 40; k++) begin
      int  p;
      bit  tr;
      cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      p = 0; tr = 0;
      for (int b = 0; b < 7; b++) begin
        if (k >= bounds[b]) p++;
        if (k == bounds[b]) tr = 1;
      end
      check_val("phase_tbl", 32'(bus.globalMode), 32'(p % 2));
      check_val("phase_rev", 32'(bus.reverseDir), tr ? 32'hF : 32'h0);
    end

    // Pellet two ticks into phase 1.
    do_reset();
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    check_val("pel_gh",  32'(bus.ghostMode),  32'hAA);
    check_val("pel_rev", 32'(bus.reverseDir), 32'hF);
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      check_val("pel_flash", 32'(bus.flash), (j == 3 || j == 4) ? 32'd1 : 32'd0);
    end
    check_val("pel_end_gh",  32'(bus.ghostMode),  32'h55);
    check_val("pel_end_rev", 32'(bus.reverseDir), 32'h0);
    for (int j = 1; j <= 4; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      check_val("pel_resume", 32'(bus.globalMode), (j < 4) ? 32'd1 : 32'd0);
    end
    check_val("pel_resume_rev", 32'(bus.reverseDir), 32'hF);

    // Eat combo in phase 2.
    cyc(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0001, 4'h0);
    check_val("eat1_ev",  32'(bus.eatValid),  32'd1);
    check_val("eat1_idx", 32'(bus.eatIdx),    32'd0);
    check_val("eat1_gh",  32'(bus.ghostMode), 32'hAB);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0110, 4'h0);
    check_val("eat2_idx", 32'(bus.eatIdx),    32'd1);
    check_val("eat2_gh",  32'(bus.ghostMode), 32'hBF);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'b0001);
    check_val("home0_gh", 32'(bus.ghostMode),  32'hBC);
    check_val("home0_gm", 32'(bus.globalMode), 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 4'b1000, 4'h0);
    check_val("eat3_idx", 32'(bus.eatIdx),    32'd3);
    check_val("eat3_gh",  32'(bus.ghostMode), 32'hFC);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'b1110);
    check_val("home_all_gh", 32'(bus.ghostMode), 32'h00);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    check_val("eat_win_end", 32'(bus.globalMode), 32'd0);

    // Pellet restart on the closing tick.
    cyc(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    check_val("rst_pre_flash", 32'(bus.flash), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
    check_val("rst_flash", 32'(bus.flash),      32'd0);
    check_val("rst_gm",    32'(bus.globalMode), 32'd2);
    check_val("rst_rev",   32'(bus.reverseDir), 32'd0);
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      check_val("rst_flash_j", 32'(bus.flash),      (j == 3 || j == 4) ? 32'd1 : 32'd0);
      check_val("rst_gm_j",    32'(bus.globalMode), (j < 5) ? 32'd2 : 32'd0);
    end

    // Freeze: events and ticks with gameEn low are dropped.
    cyc(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'hF, 4'hF);
      check_val("frz_rev", 32'(bus.reverseDir), 32'd0);
      check_val("frz_ev",  32'(bus.eatValid),   32'd0);
      check_val("frz_gm",  32'(bus.globalMode), 32'd2);
      check_val("frz_gh",  32'(bus.ghostMode),  32'hAA);
    end
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    check_val("frz_resume_flash", 32'(bus.flash),      32'd1);
    check_val("frz_resume_gm",    32'(bus.globalMode), 32'd2);

    // Asynchronous reset between clock edges mid-window.
    #3;
    reset = 1'b0;
    #1;
    check_cleared("areset");
    @(posedge clk);
    #1;
    model_reset();
    exp_q.delete();
    reset = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      check_val("post_rst_gm", 32'(bus.globalMode), (j < 4) ? 32'd0 : 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
